// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LSU memory port arbiter.
// Pure type/constant package; no logic, no latency, no flow control.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, LSU) and memory-side signals of the arbiter, bundled as one port.
// slave = arbiter view; master = view of the surrounding requesters and memory.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  lsu_req;
  logic                  lsu_we;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [BE_WIDTH-1:0]   lsu_be;
  logic                  lsu_done;
  logic [DATA_WIDTH-1:0] lsu_rdata;

  logic                  err;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  if_req, if_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    input  mem_rdata, mem_ack,
    output if_done, if_rdata, lsu_done, lsu_rdata, err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    output mem_rdata, mem_ack,
    input  if_done, if_rdata, lsu_done, lsu_rdata, err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Owner select (combinational, LSU-first) with a registered IF starvation counter.
// Counter advances only on grant; owner is valid whenever a request is present.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic             lsu_req,
  input  logic             grant,
  output owner_t           owner,
  output logic [CNT_W-1:0] starve_cnt
);

  logic starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    owner = OWN_LSU;
    if (if_req && (!lsu_req || starved)) begin
      owner = OWN_IF;
    end
  end

  // Counts LSU wins that bypassed a waiting IF; never exceeds STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (owner == OWN_IF) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and LSU: IDLE -> BUSY (mem_req until ack/timeout) -> RESP (done).
// Min 2 cycles req->done; requesters hold req until done, memory stalls by withholding mem_ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int TO_W  = $clog2(TIMEOUT);

  state_t                state_q, state_d;
  owner_t                owner_q, sel_owner;
  logic                  grant;
  logic                  timeout;
  logic [TO_W-1:0]       to_cnt;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] lsu_rdata_q;
  logic [DATA_WIDTH-1:0] rsp_data;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (bus.if_req),
    .lsu_req    (bus.lsu_req),
    .grant      (grant),
    .owner      (sel_owner),
    .starve_cnt (starve_cnt)
  );

  assign timeout  = (to_cnt == TO_W'(TIMEOUT - 1));
  assign rsp_data = bus.mem_ack ? bus.mem_rdata : '0;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.lsu_req) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack || timeout) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured once at grant so mem_* cannot follow requester changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      to_cnt      <= '0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= sel_owner;
        to_cnt  <= '0;
        if (sel_owner == OWN_IF) begin
          we_q    <= 1'b0;
          addr_q  <= bus.if_addr;
          wdata_q <= '0;
          be_q    <= '1;
        end else begin
          we_q    <= bus.lsu_we;
          addr_q  <= bus.lsu_addr;
          wdata_q <= bus.lsu_wdata;
          be_q    <= bus.lsu_be;
        end
      end
      if (state_q == BUSY) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (bus.mem_ack || timeout) begin
          err_q <= !bus.mem_ack;
          if (owner_q == OWN_IF) begin
            if_rdata_q <= rsp_data;
          end else begin
            lsu_rdata_q <= rsp_data;
          end
        end
      end
    end
  end

  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  assign bus.if_done   = (state_q == RESP) && (owner_q == OWN_IF);
  assign bus.lsu_done  = (state_q == RESP) && (owner_q == OWN_LSU);
  assign bus.err       = (state_q == RESP) && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand sequences
// for arbitration, starvation, timeout, async reset and field stability.
module tb_mem_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .STARVE_MAX (4),
    .TIMEOUT    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit            lsu;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int            ack_dly;   // BUSY cycles before ack; large = never
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    int            exp_lat;   // cycles from req drive to done
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = '0;
    bus.lsu_wdata = '0;
    bus.lsu_be    = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic wait_busy(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (!bus.mem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, " mem_req"}, bus.mem_req, 1'b1);
  endtask

  task automatic ack(input logic [DW-1:0] d);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = d;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    bit            done_seen = 1'b0;
    bit            stable    = 1'b1;
    int            busy      = 0;
    logic          exp_we    = v.lsu ? v.we : 1'b0;
    logic [BW-1:0] exp_be    = v.lsu ? v.be : {BW{1'b1}};
    @(negedge clk);
    if (v.lsu) begin
      bus.lsu_req   = 1'b1;
      bus.lsu_we    = v.we;
      bus.lsu_addr  = v.addr;
      bus.lsu_wdata = v.wdata;
      bus.lsu_be    = v.be;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.if_done || bus.lsu_done) begin
        done_seen = 1'b1;
        check($sformatf("v%0d done_owner", idx), {bus.lsu_done, bus.if_done}, v.lsu ? 2'b10 : 2'b01);
        check($sformatf("v%0d rdata", idx), v.lsu ? bus.lsu_rdata : bus.if_rdata, v.exp_rdata);
        check($sformatf("v%0d err", idx), bus.err, v.exp_err);
        check($sformatf("v%0d latency", idx), c, v.exp_lat);
      end else if (bus.mem_req) begin
        if (bus.mem_we !== exp_we || bus.mem_addr !== v.addr || bus.mem_be !== exp_be ||
            (exp_we && bus.mem_wdata !== v.wdata))
          stable = 1'b0;
        if (busy == v.ack_dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = v.rdata;
        end
        busy++;
      end
    end
    check($sformatf("v%0d done_seen", idx), done_seen, 1'b1);
    check($sformatf("v%0d mem_fields", idx), stable && busy > 0, 1'b1);
    bus.if_req  = 1'b0;
    bus.lsu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic [5:0]    order;
    int            n_busy;
    bit            got_done;
    bit            any_done;
    vec_t          fresh;

    //        lsu we addr          wdata       be     dly  rdata                   exp_rdata               err lat
    vecs[0] = '{0, 0, 32'h0000_0040, 64'h0,    8'h00, 0,   64'h13,                 64'h13,                 0,  2};
    vecs[1] = '{1, 0, 32'h0000_1000, 64'h0,    8'h00, 2,   64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, 0,  4};
    vecs[2] = '{1, 1, 32'h0000_2008, 64'h55AA, 8'h0F, 1,   64'h77,                 64'h77,                 0,  3};
    vecs[3] = '{0, 0, 32'h0000_0044, 64'h0,    8'h00, 3,   64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0001, 0,  5};
    vecs[4] = '{1, 0, 32'h0000_3000, 64'h0,    8'h00, 999, 64'h0,                  64'h0,                  1,  17};

    idle_inputs();
    #12;
    check("reset mem_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be}, 64'h0);
    check("reset dones", {bus.if_done, bus.lsu_done, bus.err}, 64'h0);
    check("reset starve_cnt", dut.starve_cnt, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

    // Simultaneous requests: LSU store first, IF in the following IDLE.
    @(negedge clk);
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h80;
    bus.lsu_wdata = 64'hAB; bus.lsu_be = 8'h01;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    wait_busy("both lsu", n);
    check("both lsu first", {bus.mem_we, bus.mem_addr, bus.mem_be}, {1'b1, 32'h80, 8'h01});
    check("both lsu wdata", bus.mem_wdata, 64'hAB);
    ack(64'h0);
    check("both lsu_done", {bus.lsu_done, bus.if_done}, 2'b10);
    bus.lsu_req = 1'b0;
    wait_busy("both if", n);
    check("both if gap", n, 1);
    check("both if second", {bus.mem_we, bus.mem_addr, bus.mem_be}, {1'b0, 32'h100, 8'hFF});
    ack(64'h2222);
    check("both if_done", {bus.lsu_done, bus.if_done}, 2'b01);
    check("both if_rdata", bus.if_rdata, 64'h2222);
    bus.if_req = 1'b0;

    // Starvation: LSU held through 6 transactions with IF pending.
    @(negedge clk);
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h500;
    bus.lsu_wdata = 64'h1; bus.lsu_be = 8'hFF;
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    order = '0;
    for (int t = 0; t < 6; t++) begin
      wait_busy($sformatf("starve t%0d", t), n);
      order[t] = !bus.mem_we;
      ack(64'h1234);
      if (bus.if_done) bus.if_req = 1'b0;
      if (t == 3) check("starve cnt at max", dut.starve_cnt, 64'd4);
      if (t == 4) check("starve cnt after if", dut.starve_cnt, 64'd0);
    end
    bus.lsu_req = 1'b0;
    check("starve grant order", order, 6'b010000);
    check("starve cnt final", dut.starve_cnt, 64'd0);

    // Timeout, then a late ack that must be ignored.
    @(negedge clk);
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h700;
    n_busy = 0;
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      if (bus.lsu_done) got_done = 1'b1;
      else if (bus.mem_req) n_busy++;
    end
    check("timeout busy cycles", n_busy, 16);
    check("timeout done", got_done, 1'b1);
    check("timeout err", bus.err, 1'b1);
    check("timeout rdata", bus.lsu_rdata, 64'h0);
    bus.lsu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ack(64'hDEAD);
    check("late ack outputs", {bus.mem_req, bus.lsu_done, bus.if_done, bus.err}, 64'h0);
    check("late ack rdata", bus.lsu_rdata, 64'h0);
    @(negedge clk);
    check("late ack idle", {bus.mem_req, bus.lsu_done, bus.if_done}, 64'h0);

    // Async reset in the middle of BUSY.
    @(negedge clk);
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h900;
    bus.lsu_wdata = 64'h99; bus.lsu_be = 8'h03;
    wait_busy("rst busy", n);
    #2 rst_n = 1'b0;
    #1;
    check("rst mem_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be}, 64'h0);
    check("rst mem_wdata", bus.mem_wdata, 64'h0);
    check("rst dones", {bus.if_done, bus.lsu_done, bus.err}, 64'h0);
    check("rst if_rdata", bus.if_rdata, 64'h0);
    check("rst lsu_rdata", bus.lsu_rdata, 64'h0);
    bus.lsu_req = 1'b0;
    any_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.if_done || bus.lsu_done) any_done = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.if_done || bus.lsu_done) any_done = 1'b1;
    check("rst no done", any_done, 1'b0);
    fresh = '{0, 0, 32'h0000_0A00, 64'h0, 8'h00, 1, 64'h5A5A, 64'h5A5A, 0, 3};
    run_txn(5, fresh);

    // Registered fields stay put while lsu_addr/lsu_wdata change during a slow ack.
    @(negedge clk);
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h300;
    bus.lsu_wdata = 64'h1122_3344_5566_7788; bus.lsu_be = 8'hF0;
    wait_busy("stab", n);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stab addr c%0d", k), {bus.mem_req, bus.mem_addr, bus.mem_be}, {1'b1, 32'h300, 8'hF0});
      check($sformatf("stab wdata c%0d", k), bus.mem_wdata, 64'h1122_3344_5566_7788);
      bus.lsu_addr  = 32'hBAD0_0000 + 32'(k);
      bus.lsu_wdata = 64'hFFFF_0000_FFFF_0000 ^ 64'(k);
      @(negedge clk);
    end
    check("stab final addr", bus.mem_addr, 64'h300);
    ack(64'h4242);
    check("stab done", {bus.lsu_done, bus.err}, 2'b10);
    check("stab rdata", bus.lsu_rdata, 64'h4242);
    bus.lsu_req = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
